// File: rtl/pixel_framer.sv
// pixel_framer: binarises a raster stream of 8-bit pixels into a HEIGHT x LENGTH
// bit image. One assembly buffer fills while one registered output frame waits
// for the downstream valid/ready handshake.
module pixel_framer #(
  parameter int HEIGHT = 28,
  parameter int LENGTH = 28,
  parameter int THRESH = 128
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           pix_valid,
  output logic                           pix_ready,
  input  logic [7:0]                     pix_data,
  input  logic                           pix_sof,
  output logic                           img_valid,
  input  logic                           img_ready,
  output logic [HEIGHT-1:0][LENGTH-1:0]  image,
  output logic                           frame_err,
  output logic [15:0]                    frame_cnt
);

  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(LENGTH - 1);
  localparam logic [7:0]    THR      = 8'(THRESH);

  logic [RW-1:0]                   row_q, row_d;
  logic [CW-1:0]                   col_q, col_d;
  logic [HEIGHT-1:0][LENGTH-1:0]   asm_q, asm_d;
  logic                            asm_full_q, asm_full_d;
  logic [HEIGHT-1:0][LENGTH-1:0]   image_q, image_d;
  logic                            img_valid_q, img_valid_d;
  logic                            frame_err_q, frame_err_d;
  logic [15:0]                     frame_cnt_q, frame_cnt_d;

  logic          accept_s;
  logic          pix_bit_s;
  logic [RW-1:0] wr_row_s;
  logic [CW-1:0] wr_col_s;
  logic          wr_last_s;
  logic          complete_s;
  logic          out_hs_s;
  logic          out_free_s;

  // Handshake qualifiers and the write position of the current beat (SOF forces (0,0)).
  always_comb begin
    accept_s   = pix_valid && !asm_full_q;
    pix_bit_s  = (pix_data >= THR);
    if (pix_sof) begin
      wr_row_s = '0;
      wr_col_s = '0;
    end else begin
      wr_row_s = row_q;
      wr_col_s = col_q;
    end
    wr_last_s  = (wr_row_s == ROW_LAST) && (wr_col_s == COL_LAST);
    complete_s = accept_s && wr_last_s;
    out_hs_s   = img_valid_q && img_ready;
    out_free_s = !img_valid_q || img_ready;
  end

  // Next-state logic: raster counters, assembly buffer, output frame and status.
  always_comb begin
    row_d       = row_q;
    col_d       = col_q;
    asm_d       = asm_q;
    asm_full_d  = asm_full_q;
    image_d     = image_q;
    img_valid_d = img_valid_q;
    frame_err_d = 1'b0;

    if (accept_s) begin
      asm_d[wr_row_s][wr_col_s] = pix_bit_s;
      if (wr_col_s == COL_LAST) begin
        col_d = '0;
        if (wr_row_s == ROW_LAST) begin
          row_d = '0;
        end else begin
          row_d = wr_row_s + 1'b1;
        end
      end else begin
        col_d = wr_col_s + 1'b1;
        row_d = wr_row_s;
      end
      // SOF away from (0,0) restarts the frame; the old partial bits get overwritten.
      if (pix_sof && ((row_q != '0) || (col_q != '0))) begin
        frame_err_d = 1'b1;
      end else begin
        frame_err_d = 1'b0;
      end
    end else begin
      frame_err_d = 1'b0;
    end

    if (complete_s) begin
      if (out_free_s) begin
        image_d     = asm_d;
        img_valid_d = 1'b1;
      end else begin
        asm_full_d  = 1'b1;
      end
    end else if (asm_full_q && out_hs_s) begin
      // Pending frame moves to the output with no bubble on img_valid.
      image_d     = asm_q;
      asm_full_d  = 1'b0;
      img_valid_d = 1'b1;
    end else if (out_hs_s) begin
      img_valid_d = 1'b0;
    end else begin
      img_valid_d = img_valid_q;
    end

    if (out_hs_s) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q       <= '0;
      col_q       <= '0;
      asm_q       <= '0;
      asm_full_q  <= 1'b0;
      image_q     <= '0;
      img_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      asm_q       <= asm_d;
      asm_full_q  <= asm_full_d;
      image_q     <= image_d;
      img_valid_q <= img_valid_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign pix_ready = !asm_full_q;
  assign img_valid = img_valid_q;
  assign image     = image_q;
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule
